// File: rtl/Common.sv
// Shared type definitions for the training datapath blocks.
package Common;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      COMPUTE,
      DONE
   } state_t;

endpackage

// File: rtl/FixedPoint.sv
// Signed fixed-point format (Q8.8) and its arithmetic helpers.
// All helpers wrap on overflow; callers needing saturation must add it themselves.
package FixedPoint;

   localparam int unsigned SFP_W    = 16;
   localparam int unsigned SFP_FRAC = 8;

   typedef logic signed [SFP_W-1:0] sfp;

   localparam sfp ONE = 16'sh0100;

   function automatic sfp sfp_add(input sfp a, input sfp b);
      return a + b;
   endfunction

   function automatic sfp sfp_sub(input sfp a, input sfp b);
      return a - b;
   endfunction

   // Full-precision product, then drop the extra fraction bits and keep the low word.
   function automatic sfp sfp_mul(input sfp a, input sfp b);
      logic signed [2*SFP_W-1:0] p;
      p = a * b;
      return p[SFP_FRAC +: SFP_W];
   endfunction

endpackage

// File: rtl/loss_gradient_unit.sv
// Output-layer loss and gradient unit.
// Captures one sample (predictions/targets), then walks the units one per cycle computing
// g = pred - tgt, storing g as the error gradient and accumulating g*g into a running loss.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               begin one sample (accepted only when idle)
//   predictions/targets per-unit inputs, registered on start
//   clear_loss          zero loss and sample_count (idle only, applied before a same-cycle start)
//   busy, done          not-idle flag, one-cycle result-valid pulse
//   error_gradient      per-unit gradient, held until overwritten
//   loss, sample_count  running sum of squared errors and saturating sample counter
module loss_gradient_unit
   import FixedPoint::*;
   import Common::*;
#(
   parameter int unsigned output_units = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  sfp          predictions    [output_units],
   input  sfp          targets        [output_units],
   input  logic        clear_loss,
   output logic        busy,
   output logic        done,
   output sfp          error_gradient [output_units],
   output sfp          loss,
   output logic [15:0] sample_count
);

   localparam int unsigned IdxW = (output_units > 1) ? $clog2(output_units) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(output_units - 1);

   state_t          state_q;
   logic [IdxW-1:0] idx_q;
   sfp              pred_q [output_units];
   sfp              tgt_q  [output_units];
   sfp              grad_q [output_units];
   sfp              loss_q;
   logic [15:0]     sample_count_q;
   logic            busy_q;
   logic            done_q;

   // One subtractor and one multiplier shared across units, steered by idx_q.
   sfp g;
   sfp g_sq;

   always_comb begin
      g    = sfp_sub(pred_q[idx_q], tgt_q[idx_q]);
      g_sq = sfp_mul(g, g);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         pred_q         <= '{default: '0};
         tgt_q          <= '{default: '0};
         grad_q         <= '{default: '0};
         loss_q         <= '0;
         sample_count_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Clear first so a same-cycle start accumulates from zero.
               if (clear_loss) begin
                  loss_q         <= '0;
                  sample_count_q <= '0;
               end
               if (start) begin
                  pred_q  <= predictions;
                  tgt_q   <= targets;
                  busy_q  <= 1'b1;
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               idx_q   <= '0;
               state_q <= COMPUTE;
            end
            COMPUTE: begin
               grad_q[idx_q] <= g;
               loss_q        <= sfp_add(loss_q, g_sq);
               idx_q         <= idx_q + 1'b1;
               if (idx_q == LastIdx) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (sample_count_q != 16'hFFFF) begin
                  sample_count_q <= sample_count_q + 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign error_gradient = grad_q;
   assign loss           = loss_q;
   assign sample_count   = sample_count_q;

endmodule

// File: tb/tb_loss_gradient_unit.sv
// Self-checking bench for loss_gradient_unit: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_loss_gradient_unit;
   import FixedPoint::*;

   localparam int unsigned N = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        clear_loss;
   sfp          p_in [N];
   sfp          t_in [N];
   logic        busy;
   logic        done;
   sfp          grad [N];
   sfp          loss;
   logic [15:0] sample_count;

   loss_gradient_unit #(.output_units(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .predictions    (p_in),
      .targets        (t_in),
      .clear_loss     (clear_loss),
      .busy           (busy),
      .done           (done),
      .error_gradient (grad),
      .loss           (loss),
      .sample_count   (sample_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model state.
   int cyc     = 0;
   int free_at = 0;   // first cycle at which the unit is idle again
   int done_at = -1;  // cycle in which done is expected
   int pend_p [N];
   int pend_t [N];
   int m_grad [N];
   int m_loss  = 0;
   int m_count = 0;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int wrap16(input int v);
      logic [15:0] b;
      b = v[15:0];
      return int'($signed(b));
   endfunction

   task automatic randomize_inputs();
      for (int i = 0; i < N; i++) begin
         p_in[i] = sfp'($urandom_range(0, 65535));
         t_in[i] = sfp'($urandom_range(0, 65535));
      end
   endtask

   // One clock cycle: check outputs for this cycle, drive inputs, advance.
   task automatic tick(input logic st, input logic clr);
      int g;
      check("busy", int'(busy), (cyc < free_at) ? 1 : 0);
      check("done", int'(done), (cyc == done_at) ? 1 : 0);
      if (cyc == done_at) begin
         for (int i = 0; i < N; i++) begin
            g         = wrap16(pend_p[i] - pend_t[i]);
            m_grad[i] = g;
            m_loss    = wrap16(m_loss + wrap16((g * g) >>> 8));
         end
         m_count = (m_count == 65535) ? 65535 : m_count + 1;
         for (int i = 0; i < N; i++) check("grad_at_done", int'(grad[i]), m_grad[i]);
         check("loss_at_done", int'(loss), m_loss);
      end else if (cyc >= free_at) begin
         for (int i = 0; i < N; i++) check("grad_idle", int'(grad[i]), m_grad[i]);
         check("loss_idle", int'(loss), m_loss);
         check("count_idle", int'(sample_count), m_count);
      end
      start      = st;
      clear_loss = clr;
      if (cyc >= free_at) begin
         if (clr) begin
            m_loss  = 0;
            m_count = 0;
         end
         if (st) begin
            for (int i = 0; i < N; i++) begin
               pend_p[i] = int'(p_in[i]);
               pend_t[i] = int'(t_in[i]);
            end
            done_at = cyc + N + 2;
            free_at = cyc + N + 3;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // pred {0.75, 0.25}, tgt {1.0, 0.0}; inputs scrambled while the sample is in flight.
   task automatic basic_sample(input logic clr);
      p_in[0] = 16'sd192;
      p_in[1] = 16'sd64;
      t_in[0] = ONE;
      t_in[1] = 16'sd0;
      tick(1'b1, clr);
      for (int k = 0; k < 6; k++) begin
         randomize_inputs();
         tick(1'b0, 1'b0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_loss"}, int'(loss), 0);
      check({tag, "_count"}, int'(sample_count), 0);
      for (int i = 0; i < N; i++) check({tag, "_grad"}, int'(grad[i]), 0);
   endtask

   task automatic model_reset();
      m_loss  = 0;
      m_count = 0;
      for (int i = 0; i < N; i++) m_grad[i] = 0;
      done_at = -1;
      free_at = 0;
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      clear_loss = 1'b0;
      for (int i = 0; i < N; i++) begin
         p_in[i] = '0;
         t_in[i] = '0;
      end
      model_reset();
      #1;
      check_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Basic sample with exact expected values.
      basic_sample(1'b0);
      check("basic_grad0", int'(grad[0]), -64);
      check("basic_grad1", int'(grad[1]), 64);
      check("basic_loss", int'(loss), 32);
      check("basic_count", int'(sample_count), 1);

      // Accumulation without clear.
      basic_sample(1'b0);
      basic_sample(1'b0);
      check("acc_loss", int'(loss), 96);
      check("acc_count", int'(sample_count), 3);

      // Clear together with start.
      basic_sample(1'b1);
      check("clr_start_loss", int'(loss), 32);
      check("clr_start_count", int'(sample_count), 1);

      // Start held high for 6 cycles with inputs changing every cycle.
      for (int k = 0; k < 6; k++) begin
         randomize_inputs();
         tick(1'b1, 1'b0);
      end
      for (int k = 0; k < 8; k++) begin
         randomize_inputs();
         tick(1'b0, 1'b0);
      end

      // Reset two cycles after start is accepted.
      randomize_inputs();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
      basic_sample(1'b0);
      check("post_reset_loss", int'(loss), 32);
      check("post_reset_count", int'(sample_count), 1);

      // Counter saturation.
      force dut.sample_count_q = 16'hFFFE;
      #1;
      release dut.sample_count_q;
      m_count = 65534;
      check("forced_count", int'(sample_count), 65534);
      basic_sample(1'b0);
      check("sat_reach", int'(sample_count), 65535);
      basic_sample(1'b0);
      check("sat_hold", int'(sample_count), 65535);
      check("sat_loss", int'(loss), 96);

      // Random traffic, including clears and starts while busy.
      for (int k = 0; k < 60; k++) begin
         randomize_inputs();
         tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      end
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/loss_gradient_unit.md
LOSS_GRADIENT_UNIT -- requirements
Module: loss_gradient_unit

Interface
REQ-001 SHALL have parameter output_units, default 2: number of output-layer perceptrons served.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request to process one sample; accepted only in IDLE.
REQ-005 SHALL have port predictions, input, sfp[output_units]: output-layer perceptron predictions.
REQ-006 SHALL have port targets, input, sfp[output_units]: expected outputs.
REQ-007 SHALL have port clear_loss, input, 1: zero the loss accumulator and sample counter.
REQ-008 SHALL have port busy, output, 1: high while not IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when error_gradient is valid.
REQ-010 SHALL have port error_gradient, output, sfp[output_units]: per-unit gradient, which feeds error_gradient_next_layer of the output layer.
REQ-011 SHALL have port loss, output, sfp: running sum of squared errors since the last clear.
REQ-012 SHALL have port sample_count, output, 16: samples accumulated since the last clear.

Function
REQ-013 SHALL implement the FSM IDLE -> CAPTURE -> COMPUTE -> DONE -> IDLE.
REQ-014 IDLE with start=1 SHALL register predictions and targets and go to CAPTURE; later input changes SHALL have no effect on the sample in flight.
REQ-015 CAPTURE SHALL clear index counter idx to 0 and go to COMPUTE.
REQ-016 COMPUTE SHALL process one element per cycle: g = sfp_sub(pred[idx], tgt[idx]), error_gradient[idx] <= g, loss <= sfp_add(loss, sfp_mul(g, g)).
REQ-017 COMPUTE SHALL increment idx, and go to DONE after the cycle where idx = output_units-1.
REQ-018 DONE SHALL assert done for exactly one cycle, increment sample_count (saturating at 16'hFFFF), and return to IDLE.
REQ-019 Latency SHALL be fixed: done high output_units+2 cycles after the cycle in which start is accepted.
REQ-020 start while busy SHALL be ignored, with no queuing.
REQ-021 error_gradient SHALL hold its last value until overwritten element-wise by the next sample.
REQ-022 clear_loss SHALL be honoured only in IDLE and ignored otherwise.
REQ-023 If clear_loss and start are high together in IDLE, the clear SHALL apply first and the new sample SHALL accumulate from zero.
REQ-024 All arithmetic SHALL use the FixedPoint sfp helpers, with no extra saturation; overflow behaviour SHALL be that of sfp_add and sfp_mul.

Reset
REQ-025 rst low SHALL immediately force state to IDLE, idx, loss, sample_count and all error_gradient elements to 0, and busy and done to 0.
REQ-026 Reset mid-COMPUTE SHALL abandon the sample; no done SHALL be produced for it.

Structure
REQ-027 The state enum (IDLE, CAPTURE, COMPUTE, DONE) SHALL be defined in package Common.
REQ-028 sfp, ONE and the sfp_* helpers SHALL come from FixedPoint, and the block SHALL add no new arithmetic functions.
REQ-029 The block SHALL be a single module with no sub-module, using one shared multiplier time-multiplexed via idx.

Verification
REQ-030 Basic sample: output_units=2, pred {0.75, 0.25}, tgt {1.0, 0.0}, start at cycle 0 -> done at cycle 4, error_gradient {-0.25, 0.25}, loss 0.125, sample_count 1.
REQ-031 Accumulation: repeat REQ-030 three times without clear -> loss 0.375, sample_count 3, one done per sample.
REQ-032 Start while busy: start held high for 6 cycles -> exactly one sample processed per IDLE entry, and inputs changed mid-COMPUTE do not alter error_gradient.
REQ-033 Clear with start: clear_loss=1 and start=1 in IDLE with loss 0.375 -> after done, loss 0.125 and sample_count 1.
REQ-034 Reset mid-COMPUTE: rst low at cycle 2 -> outputs 0 the same cycle, no done, and the next start behaves as in REQ-030.
REQ-035 Saturation: force sample_count to 16'hFFFF, then run one sample -> sample_count stays 16'hFFFF and loss still updates.
